// File: rtl/destroy_pkg.sv
// rtl/destroy_pkg.sv - shared types and default constants for the hit resolver
//
// Holds the resolver FSM state type, the default geometry constants that the
// per-plane coordinate registers also use, and a counter-width helper.

package destroy_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_t;

    localparam int N_PLANES_DEF = 10;
    localparam int X_W_DEF      = 8;
    localparam int Y_W_DEF      = 7;
    localparam int HIT_TOL_DEF  = 0;
    localparam int COOLDOWN_DEF = 8;
    localparam int SCORE_W_DEF  = 10;

    // Width able to hold 0..c, never less than one bit.
    function automatic int cnt_width(input int c);
        return (c < 1) ? 1 : $clog2(c + 1);
    endfunction

endpackage

// File: rtl/destroy_ctrl_target_select.sv
// rtl/destroy_ctrl_target_select.sv - combinational candidate filter and lowest-on-screen pick
//
// Module target_select.
// Ports:
//   self_x  player X
//   x_in    packed plane X coordinates, plane i at [i*X_W +: X_W]
//   y_in    packed plane Y coordinates, same packing
//   alive   plane i currently on screen
//   win     one-hot winning plane (all zero when nothing qualifies)
//   hit     at least one candidate exists

module target_select
    import destroy_pkg::*;
#(
    parameter int N_PLANES = N_PLANES_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int HIT_TOL  = HIT_TOL_DEF
) (
    input  logic [X_W-1:0]          self_x,
    input  logic [N_PLANES*X_W-1:0] x_in,
    input  logic [N_PLANES*Y_W-1:0] y_in,
    input  logic [N_PLANES-1:0]     alive,
    output logic [N_PLANES-1:0]     win,
    output logic                    hit
);

    localparam logic [X_W:0] TOL = (X_W + 1)'(HIT_TOL);

    logic [N_PLANES-1:0] cand;
    logic [Y_W-1:0]      best_y;

    // Distance is taken on zero-extended values, so planes near the opposite
    // screen edge never look close through wrap-around.
    for (genvar g = 0; g < N_PLANES; g++) begin : g_cand
        logic [X_W:0] xa;
        logic [X_W:0] sa;
        logic [X_W:0] dx;
        assign xa      = {1'b0, x_in[g*X_W +: X_W]};
        assign sa      = {1'b0, self_x};
        assign dx      = (xa >= sa) ? (xa - sa) : (sa - xa);
        assign cand[g] = alive[g] && (dx <= TOL);
    end

    // Strictly-greater comparison keeps the lowest index on equal Y.
    always_comb begin
        win    = '0;
        hit    = 1'b0;
        best_y = '0;
        for (int i = 0; i < N_PLANES; i++) begin
            if (cand[i] && (!hit || (y_in[i*Y_W +: Y_W] > best_y))) begin
                win    = '0;
                win[i] = 1'b1;
                hit    = 1'b1;
                best_y = y_in[i*Y_W +: Y_W];
            end
        end
    end

endmodule

// File: rtl/destroy_ctrl.sv
// rtl/destroy_ctrl.sv - registered hit resolver with fire edge detect, cooldown and score
//
// Build option: DESTROY_SCORE_EN enables the saturating score counter;
// without it score is tied to zero and no counter flops exist.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   fire         fire button level
//   self_x       player X
//   x_in, y_in   packed plane coordinates
//   alive        plane on-screen flags
//   des          one-cycle one-hot destroy pulse
//   miss         one-cycle pulse for an accepted shot that hit nothing
//   busy         cooldown in progress
//   score        destroyed-plane count

module destroy_ctrl
    import destroy_pkg::*;
#(
    parameter int N_PLANES = N_PLANES_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int HIT_TOL  = HIT_TOL_DEF,
    parameter int COOLDOWN = COOLDOWN_DEF,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    fire,
    input  logic [X_W-1:0]          self_x,
    input  logic [N_PLANES*X_W-1:0] x_in,
    input  logic [N_PLANES*Y_W-1:0] y_in,
    input  logic [N_PLANES-1:0]     alive,
    output logic [N_PLANES-1:0]     des,
    output logic                    miss,
    output logic                    busy,
    output logic [SCORE_W-1:0]      score
);

    localparam int CNT_W = cnt_width(COOLDOWN);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                fire_q;
    logic                req;
    logic                accept;
    logic [N_PLANES-1:0] win;
    logic                hit;

    target_select #(
        .N_PLANES(N_PLANES),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .HIT_TOL (HIT_TOL)
    ) u_target_select (
        .self_x(self_x),
        .x_in  (x_in),
        .y_in  (y_in),
        .alive (alive),
        .win   (win),
        .hit   (hit)
    );

    // fire_q resets high so a button held through reset release is not an edge.
    assign req    = fire & ~fire_q;
    assign accept = req & (state == IDLE);
    assign busy   = (state == COOL);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept && (COOLDOWN > 0)) begin
                    state_nx = COOL;
                    cnt_nx   = CNT_W'(COOLDOWN);
                end
            end
            COOL: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            fire_q <= 1'b1;
            des    <= '0;
            miss   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            fire_q <= fire;
            des    <= accept ? win : '0;
            miss   <= accept & ~hit;
        end
    end

`ifdef DESTROY_SCORE_EN
    logic [SCORE_W-1:0] score_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q <= '0;
        end else if (accept && hit && (score_q != {SCORE_W{1'b1}})) begin
            score_q <= score_q + SCORE_W'(1);
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_destroy_ctrl.sv
// tb/tb_destroy_ctrl.sv - self-checking bench for destroy_ctrl

module tb_destroy_ctrl;

    localparam int N  = 10;
    localparam int XW = 8;
    localparam int YW = 7;
`ifdef DESTROY_SCORE_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn;
    logic            fire;
    logic [XW-1:0]   self_x;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N-1:0]    alive;
    logic [N-1:0]    des0, des1;
    logic            miss0, miss1, busy0, busy1;
    logic [9:0]      score0;
    logic [1:0]      score1;

    destroy_ctrl #(.N_PLANES(N), .X_W(XW), .Y_W(YW), .HIT_TOL(0), .COOLDOWN(8), .SCORE_W(10)) dut0 (
        .clk(clk), .resetn(resetn), .fire(fire), .self_x(self_x), .x_in(x_in), .y_in(y_in),
        .alive(alive), .des(des0), .miss(miss0), .busy(busy0), .score(score0)
    );

    destroy_ctrl #(.N_PLANES(N), .X_W(XW), .Y_W(YW), .HIT_TOL(2), .COOLDOWN(0), .SCORE_W(2)) dut1 (
        .clk(clk), .resetn(resetn), .fire(fire), .self_x(self_x), .x_in(x_in), .y_in(y_in),
        .alive(alive), .des(des1), .miss(miss1), .busy(busy1), .score(score1)
    );

    // Reference model: a shot at edge e is accepted unless it falls within
    // COOLDOWN edges after the previous accepted shot.
    int           tol [2] = '{0, 2};
    int           cool[2] = '{8, 0};
    int           smax[2] = '{1023, 3};
    bit           prev_fire;
    bit           has_acc [2];
    int           last_acc[2];
    int           e;
    logic [N-1:0] exp_des [2];
    bit           exp_miss[2];
    bit           exp_busy[2];
    int           exp_score[2];
    int           tests;
    int           fails;

    task automatic model_reset();
        prev_fire = 1'b1;
        for (int d = 0; d < 2; d++) begin
            has_acc[d]   = 1'b0;
            last_acc[d]  = 0;
            exp_des[d]   = '0;
            exp_miss[d]  = 1'b0;
            exp_busy[d]  = 1'b0;
            exp_score[d] = 0;
        end
    endtask

    function automatic int pick(input int t);
        int best = -1;
        int by   = -1;
        for (int i = 0; i < N; i++) begin
            int xi = int'(x_in[i*XW +: XW]);
            int yi = int'(y_in[i*YW +: YW]);
            int dd = xi - int'(self_x);
            if (dd < 0) dd = -dd;
            if (alive[i] && dd <= t && yi > by) begin
                best = i;
                by   = yi;
            end
        end
        return best;
    endfunction

    task automatic tick();
        bit           req;
        bit           acc;
        int           w;
        logic [N-1:0] one;
        one = 1;
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            req       = fire && !prev_fire;
            prev_fire = fire;
            for (int d = 0; d < 2; d++) begin
                w   = pick(tol[d]);
                acc = req && !(has_acc[d] && e <= last_acc[d] + cool[d]);
                exp_des[d]  = (acc && w >= 0) ? (one << w) : '0;
                exp_miss[d] = acc && (w < 0);
                if (acc) begin
                    has_acc[d]  = 1'b1;
                    last_acc[d] = e;
                    if (w >= 0 && SC_EN && exp_score[d] < smax[d]) exp_score[d]++;
                end
                exp_busy[d] = has_acc[d] && (e + 1 <= last_acc[d] + cool[d]);
            end
        end
        e++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        fire = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_planes();
        alive = '0;
        x_in  = '0;
        y_in  = '0;
    endtask

    task automatic set_plane(input int i, input int x, input int y);
        x_in[i*XW +: XW] = XW'(x);
        y_in[i*YW +: YW] = YW'(y);
        alive[i]         = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        fire   = 1'b1;
        clear_planes();
        self_x = 8'd40;
        set_plane(3, 40, 50);
        tick();
        tick();
        tests++;
        if ({des0, des1, miss0, miss1, busy0, busy1} !== '0 || score0 !== 10'd0 || score1 !== 2'd0) begin
            fails++;
            $display("FAIL reset_values des0=%h des1=%h miss=%b%b busy=%b%b score=%0d/%0d required all zero",
                     des0, des1, miss0, miss1, busy0, busy1, score0, score1);
        end
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({des0, des1, miss0, miss1} !== '0) begin
                fails++;
                $display("FAIL no_shot_at_release cycle %0d des0=%h des1=%h miss=%b%b required 0", k, des0, des1, miss0, miss1);
            end
        end
    endtask

    task automatic test_single_hit();
        int nb;
        idle(2);
        clear_planes();
        self_x = 8'd40;
        set_plane(3, 40, 50);
        fire = 1'b1;
        tick();
        tests++;
        if (des0 !== 10'h008 || des1 !== 10'h008 || miss0 !== 1'b0) begin
            fails++;
            $display("FAIL single_hit des0=%h des1=%h miss0=%b required 008/008/0", des0, des1, miss0);
        end
        tests++;
        if (score0 !== (SC_EN ? 10'd1 : 10'd0) || busy0 !== 1'b1) begin
            fails++;
            $display("FAIL single_hit_score score0=%0d busy0=%b required %0d/1", score0, busy0, SC_EN);
        end
        nb = busy0;
        fire = 1'b0;
        tick();
        tests++;
        if (des0 !== '0) begin
            fails++;
            $display("FAIL pulse_width des0=%h required 000", des0);
        end
        nb += busy0;
        repeat (11) begin
            tick();
            nb += busy0;
        end
        tests++;
        if (nb != 8) begin
            fails++;
            $display("FAIL busy_length got %0d cycles required 8", nb);
        end
    endtask

    task automatic test_priority();
        clear_planes();
        self_x = 8'd40;
        set_plane(2, 40, 30);
        set_plane(7, 40, 90);
        fire = 1'b1;
        tick();
        tests++;
        if (des0 !== 10'h080) begin
            fails++;
            $display("FAIL priority_max_y des0=%h required 080", des0);
        end
        idle(10);
        clear_planes();
        set_plane(4, 40, 60);
        set_plane(6, 40, 60);
        fire = 1'b1;
        tick();
        tests++;
        if (des0 !== 10'h010) begin
            fails++;
            $display("FAIL priority_tie des0=%h required 010", des0);
        end
        idle(10);
    endtask

    task automatic test_no_wrap();
        clear_planes();
        self_x = 8'd1;
        set_plane(0, 255, 100);
        set_plane(1, 3, 10);
        fire = 1'b1;
        tick();
        tests++;
        if (des1 !== 10'h002 || miss0 !== 1'b1 || des0 !== '0) begin
            fails++;
            $display("FAIL tolerance des1=%h miss0=%b des0=%h required 002/1/000", des1, miss0, des0);
        end
        idle(10);
        clear_planes();
        set_plane(0, 255, 100);
        fire = 1'b1;
        tick();
        tests++;
        if (des1 !== '0 || miss1 !== 1'b1) begin
            fails++;
            $display("FAIL no_wrap des1=%h miss1=%b required 000/1", des1, miss1);
        end
        idle(10);
    endtask

    task automatic test_miss_cooldown();
        clear_planes();
        self_x = 8'd40;
        fire   = 1'b1;
        tick();
        tests++;
        if (miss0 !== 1'b1 || des0 !== '0 || score0 !== 10'(exp_score[0])) begin
            fails++;
            $display("FAIL miss_pulse miss0=%b des0=%h score0=%0d required 1/000/%0d", miss0, des0, score0, exp_score[0]);
        end
        fire = 1'b0;
        tick();
        tick();
        fire = 1'b1;
        tick();
        tests++;
        if (miss0 !== 1'b0 || des0 !== '0) begin
            fails++;
            $display("FAIL dropped_in_cool miss0=%b des0=%h required 0/000", miss0, des0);
        end
        fire = 1'b0;
        repeat (5) tick();
        fire = 1'b1;
        tick();
        tests++;
        if (miss0 !== 1'b1) begin
            fails++;
            $display("FAIL accept_after_cool miss0=%b required 1", miss0);
        end
        idle(10);
    endtask

    task automatic test_fire_hold();
        int n;
        clear_planes();
        self_x = 8'd40;
        set_plane(3, 40, 50);
        fire = 1'b1;
        n    = 0;
        repeat (20) begin
            tick();
            if (des0 !== '0) n++;
        end
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL fire_hold got %0d shots required 1", n);
        end
        idle(10);
    endtask

    task automatic test_score_sat();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        clear_planes();
        self_x = 8'd40;
        set_plane(3, 40, 50);
        for (int k = 1; k <= 5; k++) begin
            fire = 1'b1;
            tick();
            fire = 1'b0;
            tick();
            tests++;
            if (score1 !== (SC_EN ? 2'((k < 3) ? k : 3) : 2'd0)) begin
                fails++;
                $display("FAIL score_sat hit %0d score1=%0d required %0d", k, score1, SC_EN ? ((k < 3) ? k : 3) : 0);
            end
        end
        idle(10);
    endtask

    task automatic test_reset_mid_cool();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        tick();
        tests++;
        if (busy0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_cool_busy busy0=%b required 1", busy0);
        end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if (busy0 !== 1'b0 || score0 !== '0 || score1 !== '0 || des0 !== '0 || miss0 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset busy0=%b score0=%0d score1=%0d des0=%h miss0=%b required all 0",
                     busy0, score0, score1, des0, miss0);
        end
        model_reset();
        tick();
        resetn = 1'b1;
        idle(3);
    endtask

    task automatic test_random();
        logic [XW-1:0] xv;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) fire = ~fire;
            case ($urandom_range(0, 9))
                0:       self_x = 8'd0;
                1:       self_x = 8'd255;
                default: self_x = XW'($urandom);
            endcase
            alive = N'($urandom);
            for (int i = 0; i < N; i++) begin
                xv = self_x + XW'($urandom_range(0, 6)) - 8'd3;
                x_in[i*XW +: XW] = xv;
                y_in[i*YW +: YW] = YW'($urandom_range(0, 7) * 16);
            end
            tick();
            tests++;
            if (des0 !== exp_des[0] || miss0 !== exp_miss[0] || busy0 !== exp_busy[0] || score0 !== 10'(exp_score[0])) begin
                fails++;
                $display("FAIL random_dut0 cycle %0d got des=%h miss=%b busy=%b score=%0d required des=%h miss=%b busy=%b score=%0d",
                         c, des0, miss0, busy0, score0, exp_des[0], exp_miss[0], exp_busy[0], exp_score[0]);
            end
            tests++;
            if (des1 !== exp_des[1] || miss1 !== exp_miss[1] || busy1 !== exp_busy[1] || score1 !== 2'(exp_score[1])) begin
                fails++;
                $display("FAIL random_dut1 cycle %0d got des=%h miss=%b busy=%b score=%0d required des=%h miss=%b busy=%b score=%0d",
                         c, des1, miss1, busy1, score1, exp_des[1], exp_miss[1], exp_busy[1], exp_score[1]);
            end
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        e      = 0;
        resetn = 1'b0;
        fire   = 1'b0;
        self_x = '0;
        x_in   = '0;
        y_in   = '0;
        alive  = '0;
        model_reset();
        test_reset();
        test_single_hit();
        test_priority();
        test_no_wrap();
        test_miss_cooldown();
        test_fire_hold();
        test_score_sat();
        test_reset_mid_cool();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
